// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares a single i2c_master between NUM_REQ requesters. Requests are granted
// round-robin, one transaction at a time. A NACKed transaction is re-issued up
// to MAX_RETRIES times before the error is returned. A watchdog aborts a
// transaction that never completes. Every master-facing and requester-facing
// output is registered.
module i2c_bus_arbiter #(
   parameter  int NUM_REQ        = 2,
   parameter  int MAX_BYTES      = 3,
   parameter  int MAX_RETRIES    = 2,
   parameter  int GAP_CYCLES     = 100,
   parameter  int TIMEOUT_CYCLES = 200000,
   localparam int BW             = $clog2(MAX_BYTES + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   // requester side
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_rd_nwr,
   input  logic [NUM_REQ*7-1:0]           req_addr,
   input  logic [NUM_REQ*8*MAX_BYTES-1:0] req_din,
   input  logic [NUM_REQ*BW-1:0]          req_bytes,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic                           rsp_error,
   output logic                           rsp_timeout,
   output logic [8*MAX_BYTES-1:0]         rsp_dout,
   // i2c_master side
   output logic                           m_start,
   output logic                           m_rd_nwr,
   output logic [6:0]                     m_slave_addr,
   output logic [8*MAX_BYTES-1:0]         m_din,
   output logic [BW-1:0]                  m_bytes,
   input  logic [8*MAX_BYTES-1:0]         m_dout,
   input  logic                           m_done,
   input  logic                           m_error,
   output logic                           m_abort
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int RW = 3;

   localparam logic [IW:0]   NUM_REQ_W  = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);
   localparam logic [BW-1:0] MAX_BYTES_W = BW'(MAX_BYTES);
   localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRIES);
   localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      GAP
   } state_t;

   state_t              state, state_d;
   logic [IW-1:0]       idx, idx_d;
   logic [IW-1:0]       rr_ptr, rr_ptr_d;
   logic [RW-1:0]       retry_cnt, retry_cnt_d;
   logic [TW-1:0]       wd_cnt, wd_cnt_d;
   logic [GW-1:0]       gap_cnt, gap_cnt_d;
   logic                retrying, retrying_d;

   logic [NUM_REQ-1:0]     grant_d, rsp_valid_d;
   logic                   rsp_error_d, rsp_timeout_d;
   logic [8*MAX_BYTES-1:0] rsp_dout_d;
   logic                   m_start_d, m_rd_nwr_d, m_abort_d;
   logic [6:0]             m_slave_addr_d;
   logic [8*MAX_BYTES-1:0] m_din_d;
   logic [BW-1:0]          m_bytes_d;

   // Per-requester views of the packed payload buses.
   logic [6:0]             addr_a  [NUM_REQ];
   logic [8*MAX_BYTES-1:0] din_a   [NUM_REQ];
   logic [BW-1:0]          bytes_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = req_addr[7*g +: 7];
      assign din_a[g]   = req_din[8*MAX_BYTES*g +: 8*MAX_BYTES];
      assign bytes_a[g] = req_bytes[BW*g +: BW];
   end

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          pick_bytes_ok;

   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IW-1:0] i);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first pending request at or after rr_ptr, wrapping.
   always_comb begin : p_pick
      logic [IW:0] sum;
      // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
      sum        = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
         if (!pick_found && req[sum[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = sum[IW-1:0];
         end
      end
      pick_bytes_ok = (bytes_a[pick_idx] != '0) && (bytes_a[pick_idx] <= MAX_BYTES_W);
   end

   // Next-state and next-output logic.
   always_comb begin : p_next
      state_d        = state;
      idx_d          = idx;
      rr_ptr_d       = rr_ptr;
      retry_cnt_d    = retry_cnt;
      wd_cnt_d       = wd_cnt;
      gap_cnt_d      = gap_cnt;
      retrying_d     = retrying;
      grant_d        = grant;
      rsp_valid_d    = '0;
      rsp_error_d    = 1'b0;
      rsp_timeout_d  = 1'b0;
      rsp_dout_d     = '0;
      m_start_d      = 1'b0;
      m_abort_d      = 1'b0;
      m_rd_nwr_d     = m_rd_nwr;
      m_slave_addr_d = m_slave_addr;
      m_din_d        = m_din;
      m_bytes_d      = m_bytes;

      unique case (state)
         IDLE: begin
            if (pick_found) begin
               idx_d       = pick_idx;
               retry_cnt_d = '0;
               if (pick_bytes_ok) begin
                  grant_d        = to_onehot(pick_idx);
                  m_rd_nwr_d     = req_rd_nwr[pick_idx];
                  m_slave_addr_d = addr_a[pick_idx];
                  m_din_d        = din_a[pick_idx];
                  m_bytes_d      = bytes_a[pick_idx];
                  state_d        = ISSUE;
               end else begin
                  // Illegal byte count: answer at once without touching the master.
                  rsp_valid_d = to_onehot(pick_idx);
                  rsp_error_d = 1'b1;
                  state_d     = RESP;
               end
            end
         end

         ISSUE: begin
            m_start_d = 1'b1;
            wd_cnt_d  = '0;
            state_d   = WAIT;
         end

         WAIT: begin
            // m_done is checked first so a completion on the expiry cycle wins.
            if (m_done) begin
               if (!m_error) begin
                  rsp_valid_d = to_onehot(idx);
                  rsp_dout_d  = m_rd_nwr ? m_dout : '0;
                  state_d     = RESP;
               end else if (retry_cnt < MAX_RETRY_W) begin
                  retry_cnt_d = retry_cnt + 1'b1;
                  retrying_d  = 1'b1;
                  gap_cnt_d   = '0;
                  state_d     = GAP;
               end else begin
                  rsp_valid_d = to_onehot(idx);
                  rsp_error_d = 1'b1;
                  state_d     = RESP;
               end
            end else if (wd_cnt == WD_LAST) begin
               m_abort_d     = 1'b1;
               rsp_valid_d   = to_onehot(idx);
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = RESP;
            end else begin
               wd_cnt_d = wd_cnt + 1'b1;
            end
         end

         RESP: begin
            grant_d    = '0;
            rr_ptr_d   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            retrying_d = 1'b0;
            gap_cnt_d  = '0;
            state_d    = GAP;
         end

         GAP: begin
            // Idle time lets the master settle back to READY before the next start.
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_d  = '0;
               retrying_d = 1'b0;
               state_d    = retrying ? ISSUE : IDLE;
            end else begin
               gap_cnt_d = gap_cnt + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Control counters and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset clears every register, so a reset mid-transaction leaves no stale response behind.
      if (reset) begin
         idx          <= '0;
         rr_ptr       <= '0;
         retry_cnt    <= '0;
         wd_cnt       <= '0;
         gap_cnt      <= '0;
         retrying     <= 1'b0;
         grant        <= '0;
         rsp_valid    <= '0;
         rsp_error    <= 1'b0;
         rsp_timeout  <= 1'b0;
         rsp_dout     <= '0;
         m_start      <= 1'b0;
         m_abort      <= 1'b0;
         m_rd_nwr     <= 1'b0;
         m_slave_addr <= '0;
         m_din        <= '0;
         m_bytes      <= '0;
      end else begin
         idx          <= idx_d;
         rr_ptr       <= rr_ptr_d;
         retry_cnt    <= retry_cnt_d;
         wd_cnt       <= wd_cnt_d;
         gap_cnt      <= gap_cnt_d;
         retrying     <= retrying_d;
         grant        <= grant_d;
         rsp_valid    <= rsp_valid_d;
         rsp_error    <= rsp_error_d;
         rsp_timeout  <= rsp_timeout_d;
         rsp_dout     <= rsp_dout_d;
         m_start      <= m_start_d;
         m_abort      <= m_abort_d;
         m_rd_nwr     <= m_rd_nwr_d;
         m_slave_addr <= m_slave_addr_d;
         m_din        <= m_din_d;
         m_bytes      <= m_bytes_d;
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter
// Directed bench for i2c_bus_arbiter with a small behavioural i2c_master that
// answers every m_start after a fixed delay, optionally NACKing or staying silent.
module tb_i2c_bus_arbiter;

   localparam int NUM_REQ    = 2;
   localparam int MAX_BYTES  = 3;
   localparam int MAX_RETRY  = 2;
   localparam int GAP        = 20;
   localparam int TMO        = 300;
   localparam int BW         = 2;
   localparam int RESP_DELAY = 4;

   logic                           clk;
   logic                           reset;
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             req_rd_nwr;
   logic [NUM_REQ*7-1:0]           req_addr;
   logic [NUM_REQ*8*MAX_BYTES-1:0] req_din;
   logic [NUM_REQ*BW-1:0]          req_bytes;
   logic [NUM_REQ-1:0]             grant;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic                           rsp_error;
   logic                           rsp_timeout;
   logic [8*MAX_BYTES-1:0]         rsp_dout;
   logic                           m_start;
   logic                           m_rd_nwr;
   logic [6:0]                     m_slave_addr;
   logic [8*MAX_BYTES-1:0]         m_din;
   logic [BW-1:0]                  m_bytes;
   logic [8*MAX_BYTES-1:0]         m_dout;
   logic                           m_done;
   logic                           m_error;
   logic                           m_abort;

   i2c_bus_arbiter #(
      .NUM_REQ(NUM_REQ), .MAX_BYTES(MAX_BYTES), .MAX_RETRIES(MAX_RETRY),
      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .req(req), .req_rd_nwr(req_rd_nwr), .req_addr(req_addr), .req_din(req_din),
      .req_bytes(req_bytes),
      .grant(grant), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
      .rsp_timeout(rsp_timeout), .rsp_dout(rsp_dout),
      .m_start(m_start), .m_rd_nwr(m_rd_nwr), .m_slave_addr(m_slave_addr),
      .m_din(m_din), .m_bytes(m_bytes), .m_dout(m_dout), .m_done(m_done),
      .m_error(m_error), .m_abort(m_abort)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Master-model knobs (written by the main sequence only).
   logic                   withhold   = 1'b0;
   int                     nack_limit = 0;
   int                     start_mark = 0;
   logic [8*MAX_BYTES-1:0] slave_data = '0;
   int                     inject_req = 0;

   // Master-model observations (written by the model only).
   int                     start_cnt = 0, start_cyc = 0, done_cyc = 0;
   int                     abort_cnt = 0, abort_cyc = 0, rsp_cnt = 0;
   int                     inject_ack = 0;
   logic [8*MAX_BYTES-1:0] start_din  = '0;
   logic [6:0]             start_addr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural master: answer RESP_DELAY cycles after each start.
   initial begin : master_model
      int pend;
      pend    = 0;
      m_done  = 1'b0;
      m_error = 1'b0;
      m_dout  = '0;
      forever begin
         @(negedge clk);
         m_done  = 1'b0;
         m_error = 1'b0;
         m_dout  = '0;
         if (m_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
         end
         if (rsp_valid != '0) rsp_cnt++;
         if (m_start) begin
            start_cnt++;
            start_cyc  = cyc;
            start_din  = m_din;
            start_addr = m_slave_addr;
            pend       = withhold ? 0 : RESP_DELAY;
         end else if (pend != 0) begin
            pend--;
            if (pend == 0) begin
               m_done   = 1'b1;
               m_error  = ((start_cnt - start_mark) <= nack_limit);
               m_dout   = slave_data;
               done_cyc = cyc;
            end
         end else if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            m_done     = 1'b1;
            m_dout     = '1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_rsp(input string tag, input int limit, output int at);
      int n;
      n = 0;
      while (rsp_valid == '0 && n < limit) begin
         tick();
         n++;
      end
      at = cyc;
      if (rsp_valid == '0) check({tag, " rsp_wait"}, 32'(n), 32'(limit - 1));
   endtask

   task automatic wait_start(input string tag, input int mark, input int limit);
      int n;
      n = 0;
      while (start_cnt == mark && n < limit) begin
         tick();
         n++;
      end
      if (start_cnt == mark) check({tag, " start_wait"}, 32'(n), 32'(limit - 1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      ticks(2);
      reset = 1'b0;
      tick();
   endtask

   task automatic set_req(input int i, input logic rd, input logic [6:0] addr,
                          input logic [23:0] din, input logic [BW-1:0] nbytes);
      req_rd_nwr[i]        = rd;
      req_addr[7*i +: 7]   = addr;
      req_din[24*i +: 24]  = din;
      req_bytes[BW*i +: BW] = nbytes;
   endtask

   initial begin : main
      int t_req, t_rsp, mark, rmark, amark, prev_start;
      logic [NUM_REQ-1:0] exp_v;

      reset      = 1'b1;
      req        = '0;
      req_rd_nwr = '0;
      req_addr   = '0;
      req_din    = '0;
      req_bytes  = '0;
      ticks(3);

      // Reset state
      check("rst grant",   32'(grant), 32'h0);
      check("rst rsp",     32'(rsp_valid), 32'h0);
      check("rst m_start", 32'(m_start), 32'h0);
      check("rst addr",    32'(m_slave_addr), 32'h0);
      reset = 1'b0;
      tick();

      // Single read of two bytes from 0x29
      set_req(0, 1'b1, 7'h29, 24'h0, 2'd2);
      slave_data = 24'h001234;
      nack_limit = 0;
      start_mark = start_cnt;
      mark       = start_cnt;
      req[0]     = 1'b1;
      t_req      = cyc;
      wait_start("rd", mark, 20);
      check("rd start lat", 32'(start_cyc - t_req), 32'd2);
      check("rd grant",     32'(grant), 32'h1);
      check("rd addr",      32'(m_slave_addr), 32'h29);
      check("rd dir",       32'(m_rd_nwr), 32'h1);
      check("rd bytes",     32'(m_bytes), 32'd2);
      wait_rsp("rd", 50, t_rsp);
      check("rd rsp lat",   32'(t_rsp - done_cyc), 32'd1);
      check("rd rsp_valid", 32'(rsp_valid), 32'h1);
      check("rd dout",      32'(rsp_dout), 32'h001234);
      check("rd error",     32'(rsp_error), 32'h0);
      req = '0;
      tick();
      check("rd grant off", 32'(grant), 32'h0);

      // Stray m_done while in GAP must be ignored
      rmark = rsp_cnt;
      inject_req++;
      ticks(6);
      check("stray done", 32'(rsp_cnt - rmark), 32'd0);
      ticks(GAP + 5);

      // Round robin with both requesters holding write requests
      do_reset();
      set_req(0, 1'b0, 7'h10, 24'hA1A2A3, 2'd3);
      set_req(1, 1'b0, 7'h20, 24'hB1B2B3, 2'd1);
      start_mark = start_cnt;
      req        = 2'b11;
      prev_start = 0;
      for (int i = 0; i < 4; i++) begin
         exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
         wait_rsp("rr", 200, t_rsp);
         check("rr order", 32'(rsp_valid), 32'(exp_v));
         check("rr grant", 32'(grant), 32'(exp_v));
         check("rr din",   32'(start_din), (i % 2 == 0) ? 32'hA1A2A3 : 32'hB1B2B3);
         check("rr addr",  32'(start_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
         check("rr dout",  32'(rsp_dout), 32'h0);
         if (i > 0) check("rr start gap", 32'(start_cyc - prev_start), 32'(GAP + 8));
         prev_start = start_cyc;
         tick();
      end
      req = '0;
      ticks(GAP + 5);

      // Slave NACKs every attempt
      set_req(0, 1'b1, 7'h50, 24'h0, 2'd1);
      nack_limit = 7;
      start_mark = start_cnt;
      req[0]     = 1'b1;
      wait_rsp("nack", 300, t_rsp);
      check("nack starts",  32'(start_cnt - start_mark), 32'(MAX_RETRY + 1));
      check("nack valid",   32'(rsp_valid), 32'h1);
      check("nack error",   32'(rsp_error), 32'h1);
      check("nack timeout", 32'(rsp_timeout), 32'h0);
      check("nack dout",    32'(rsp_dout), 32'h0);
      req = '0;
      ticks(GAP + 5);

      // NACK on first attempt, ACK on retry
      set_req(1, 1'b1, 7'h44, 24'h0, 2'd2);
      nack_limit = 1;
      slave_data = 24'h00ABCD;
      start_mark = start_cnt;
      req[1]     = 1'b1;
      wait_rsp("retry", 300, t_rsp);
      check("retry starts", 32'(start_cnt - start_mark), 32'd2);
      check("retry valid",  32'(rsp_valid), 32'h2);
      check("retry error",  32'(rsp_error), 32'h0);
      check("retry dout",   32'(rsp_dout), 32'h00ABCD);
      req = '0;
      ticks(GAP + 5);

      // Watchdog abort when m_done never comes
      nack_limit = 0;
      withhold   = 1'b1;
      set_req(0, 1'b0, 7'h11, 24'h000055, 2'd1);
      amark      = abort_cnt;
      mark       = start_cnt;
      req[0]     = 1'b1;
      wait_start("tmo", mark, 20);
      wait_rsp("tmo", TMO + 50, t_rsp);
      check("tmo abort lat", 32'(abort_cyc - start_cyc), 32'(TMO));
      check("tmo abort",     32'(m_abort), 32'h1);
      check("tmo valid",     32'(rsp_valid), 32'h1);
      check("tmo error",     32'(rsp_error), 32'h1);
      check("tmo timeout",   32'(rsp_timeout), 32'h1);
      tick();
      check("tmo abort cnt", 32'(abort_cnt - amark), 32'd1);
      req      = '0;
      withhold = 1'b0;
      ticks(GAP + 5);

      // Normal service after the abort
      set_req(0, 1'b1, 7'h12, 24'h0, 2'd3);
      slave_data = 24'h5A5A5A;
      start_mark = start_cnt;
      req[0]     = 1'b1;
      wait_rsp("post", 100, t_rsp);
      check("post error",   32'(rsp_error), 32'h0);
      check("post timeout", 32'(rsp_timeout), 32'h0);
      check("post dout",    32'(rsp_dout), 32'h5A5A5A);
      req = '0;
      ticks(GAP + 5);

      // Zero byte count: answered immediately, master untouched
      set_req(1, 1'b1, 7'h21, 24'h0, 2'd0);
      mark   = start_cnt;
      req[1] = 1'b1;
      t_req  = cyc;
      wait_rsp("zero", 20, t_rsp);
      check("zero lat",    32'(t_rsp - t_req), 32'd1);
      check("zero valid",  32'(rsp_valid), 32'h2);
      check("zero error",  32'(rsp_error), 32'h1);
      check("zero grant",  32'(grant), 32'h0);
      req = '0;
      ticks(GAP + 5);
      check("zero starts", 32'(start_cnt - mark), 32'd0);

      // Reset while waiting on the master
      withhold = 1'b1;
      set_req(0, 1'b1, 7'h33, 24'h0, 2'd2);
      mark   = start_cnt;
      req[0] = 1'b1;
      wait_start("wrst", mark, 20);
      ticks(3);
      reset = 1'b1;
      req   = '0;
      tick();
      check("wrst grant",   32'(grant), 32'h0);
      check("wrst m_rd",    32'(m_rd_nwr), 32'h0);
      check("wrst addr",    32'(m_slave_addr), 32'h0);
      check("wrst bytes",   32'(m_bytes), 32'h0);
      check("wrst rsp",     32'({rsp_valid, rsp_error, rsp_timeout}), 32'h0);
      check("wrst dout",    32'(rsp_dout), 32'h0);
      check("wrst m_start", 32'({m_start, m_abort}), 32'h0);
      reset    = 1'b0;
      withhold = 1'b0;
      rmark    = rsp_cnt;
      amark    = abort_cnt;
      ticks(TMO + 20);
      check("wrst no rsp",   32'(rsp_cnt - rmark), 32'd0);
      check("wrst no abort", 32'(abort_cnt - amark), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
